// File: rtl/object_motion_gen.sv
// object_motion_gen: single-sprite motion engine with wall-bounce and
// projectile (gravity) modes, launch/kill lifetime control and event pulses.
module object_motion_gen #(
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int CNT_W    = 32,
   parameter int VY_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             launch,
   input  logic [X_W-1:0]   init_x,
   input  logic [Y_W-1:0]   init_y,
   input  logic [X_W-1:0]   obj_w,
   input  logic [Y_W-1:0]   obj_h,
   input  logic [CNT_W-1:0] tx,
   input  logic [CNT_W-1:0] ty,
   input  logic             dir_x,
   input  logic [VY_W-1:0]  vy0,
   input  logic [CNT_W-1:0] grav_period,
   input  logic             mode,
   input  logic             kill,
   output logic [X_W-1:0]   pos_x,
   output logic [Y_W-1:0]   pos_y,
   output logic             active,
   output logic             launch_ack,
   output logic             bounce_x,
   output logic             bounce_y,
   output logic             exited
);

   localparam int XS = X_W + 2;
   localparam int YS = Y_W + 2;
   localparam int VS = VY_W + 2;

   localparam logic signed [XS-1:0] X_SCR  = XS'(SCREEN_W);
   localparam logic signed [XS-1:0] X_ONE  = XS'(1);
   localparam logic signed [YS-1:0] Y_SCR  = YS'(SCREEN_H);
   localparam logic signed [VS-1:0] VY_ONE = VS'(1);
   localparam logic signed [VS-1:0] VY_MAX = VS'((1 << (VY_W - 1)) - 1);

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [X_W-1:0]         pos_x_q, pos_x_d;
   logic [Y_W-1:0]         pos_y_q, pos_y_d;
   logic signed [VY_W-1:0] vy_q, vy_d;
   logic                   dir_q, dir_d;
   logic [CNT_W-1:0]       cnt_x_q, cnt_x_d;
   logic [CNT_W-1:0]       cnt_y_q, cnt_y_d;
   logic [CNT_W-1:0]       cnt_g_q, cnt_g_d;
   logic [CNT_W-1:0]       tx_q, tx_d;
   logic [CNT_W-1:0]       ty_q, ty_d;
   logic [CNT_W-1:0]       gp_q, gp_d;
   logic                   mode_q, mode_d;
   logic [X_W-1:0]         w_q, w_d;
   logic [Y_W-1:0]         h_q, h_d;
   logic                   ack_q, ack_d;
   logic                   bx_q, bx_d;
   logic                   by_q, by_d;
   logic                   ex_q, ex_d;

   logic                   tick_x, tick_y, tick_g;
   logic signed [XS-1:0]   cand_x, x_max;
   logic                   x_oob;
   logic signed [YS-1:0]   vy_y, next_y, y_max;
   logic signed [VS-1:0]   vy_v, vy_n;

   function automatic logic tick(input logic [CNT_W-1:0] cnt,
                                 input logic [CNT_W-1:0] p);
      return (p != '0) && (cnt == p - CNT_W'(1));
   endfunction

   function automatic logic [CNT_W-1:0] cnt_adv(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] p);
      return (tick(cnt, p) || (p == '0)) ? '0 : cnt + CNT_W'(1);
   endfunction

   assign tick_x = tick(cnt_x_q, tx_q);
   assign tick_y = tick(cnt_y_q, ty_q);
   assign tick_g = mode_q && tick(cnt_g_q, gp_q);

   assign cand_x = dir_q ? $signed({2'b00, pos_x_q}) - X_ONE
                         : $signed({2'b00, pos_x_q}) + X_ONE;
   assign x_max  = X_SCR - $signed({2'b00, w_q});
   assign x_oob  = cand_x[XS-1] || (cand_x > x_max);

   assign vy_y   = {{(YS - VY_W){vy_q[VY_W-1]}}, vy_q};
   assign vy_v   = {{2{vy_q[VY_W-1]}}, vy_q};
   assign next_y = $signed({2'b00, pos_y_q}) + vy_y;
   assign y_max  = Y_SCR - $signed({2'b00, h_q});

   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      vy_d    = vy_q;
      dir_d   = dir_q;
      cnt_x_d = cnt_x_q;
      cnt_y_d = cnt_y_q;
      cnt_g_d = cnt_g_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      gp_d    = gp_q;
      mode_d  = mode_q;
      w_d     = w_q;
      h_d     = h_q;
      ack_d   = 1'b0;
      bx_d    = 1'b0;
      by_d    = 1'b0;
      ex_d    = 1'b0;
      vy_n    = vy_v;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d = MOVE;
               pos_x_d = init_x;
               pos_y_d = init_y;
               dir_d   = dir_x;
               vy_d    = vy0;
               tx_d    = tx;
               ty_d    = ty;
               gp_d    = grav_period;
               mode_d  = mode;
               w_d     = obj_w;
               h_d     = obj_h;
               cnt_x_d = '0;
               cnt_y_d = '0;
               cnt_g_d = '0;
               ack_d   = 1'b1;
            end
         end
         MOVE: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               cnt_x_d = cnt_adv(cnt_x_q, tx_q);
               cnt_y_d = cnt_adv(cnt_y_q, ty_q);
               cnt_g_d = cnt_adv(cnt_g_q, gp_q);
               // Leaving through the floor freezes the sprite where it was
               if (tick_y && mode_q && (next_y >= Y_SCR)) begin
                  ex_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  if (tick_x) begin
                     if (x_oob) begin
                        dir_d = ~dir_q;
                        bx_d  = 1'b1;
                     end else begin
                        pos_x_d = cand_x[X_W-1:0];
                     end
                  end
                  if (tick_y) begin
                     if (next_y[YS-1]) begin
                        pos_y_d = '0;
                        vy_n    = -vy_v;
                        by_d    = 1'b1;
                     end else if (!mode_q && (next_y > y_max)) begin
                        pos_y_d = y_max[Y_W-1:0];
                        vy_n    = -vy_v;
                        by_d    = 1'b1;
                     end else begin
                        pos_y_d = next_y[Y_W-1:0];
                     end
                  end
                  if (tick_g) begin
                     vy_n = vy_n + VY_ONE;
                  end
                  vy_d = (vy_n > VY_MAX) ? VY_MAX[VY_W-1:0]
                                         : vy_n[VY_W-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pos_x_q <= '0;
         pos_y_q <= '0;
         vy_q    <= '0;
         dir_q   <= 1'b0;
         cnt_x_q <= '0;
         cnt_y_q <= '0;
         cnt_g_q <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
         gp_q    <= '0;
         mode_q  <= 1'b0;
         w_q     <= '0;
         h_q     <= '0;
         ack_q   <= 1'b0;
         bx_q    <= 1'b0;
         by_q    <= 1'b0;
         ex_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         vy_q    <= vy_d;
         dir_q   <= dir_d;
         cnt_x_q <= cnt_x_d;
         cnt_y_q <= cnt_y_d;
         cnt_g_q <= cnt_g_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         gp_q    <= gp_d;
         mode_q  <= mode_d;
         w_q     <= w_d;
         h_q     <= h_d;
         ack_q   <= ack_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         ex_q    <= ex_d;
      end
   end

   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign active     = (state_q == MOVE);
   assign launch_ack = ack_q;
   assign bounce_x   = bx_q;
   assign bounce_y   = by_q;
   assign exited     = ex_q;

endmodule

// File: tb/tb_object_motion_gen.sv
// Scoreboard bench for object_motion_gen: directed scenarios plus random
// traffic, checked against an integer-arithmetic reference model.
module tb_object_motion_gen;

   localparam int SW = 640;
   localparam int SH = 480;

   logic        clk;
   logic        rst;
   logic        launch;
   logic [9:0]  init_x;
   logic [8:0]  init_y;
   logic [9:0]  obj_w;
   logic [8:0]  obj_h;
   logic [31:0] tx;
   logic [31:0] ty;
   logic        dir_x;
   logic [7:0]  vy0;
   logic [31:0] grav_period;
   logic        mode;
   logic        kill;
   logic [9:0]  pos_x;
   logic [8:0]  pos_y;
   logic        active;
   logic        launch_ack;
   logic        bounce_x;
   logic        bounce_y;
   logic        exited;

   object_motion_gen dut (
      .clk(clk), .rst(rst), .launch(launch),
      .init_x(init_x), .init_y(init_y),
      .obj_w(obj_w), .obj_h(obj_h),
      .tx(tx), .ty(ty), .dir_x(dir_x), .vy0(vy0),
      .grav_period(grav_period), .mode(mode), .kill(kill),
      .pos_x(pos_x), .pos_y(pos_y), .active(active),
      .launch_ack(launch_ack), .bounce_x(bounce_x),
      .bounce_y(bounce_y), .exited(exited)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int flags;
   } exp_t;

   exp_t q[$];
   int   n_cmp;
   int   n_bad;

   // Reference model state
   bit     mmov;
   int     mx, my, mvy, mdir;
   int     mtx, mty, mgp, mw, mh;
   bit     mmode;
   longint mt;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
      end
   endtask

   task automatic model_step();
      exp_t e;
      bit ack, bx, by, ex, xt, yt, gt;
      int ny, c, nv;
      ack = 0; bx = 0; by = 0; ex = 0;
      if (rst) begin
         mmov = 0; mx = 0; my = 0; mvy = 0; mdir = 1;
      end else if (!mmov) begin
         if (launch) begin
            mmov = 1; ack = 1; mt = 0;
            mx = int'(init_x); my = int'(init_y);
            mdir = dir_x ? -1 : 1;
            mvy = int'($signed(vy0));
            mtx = int'(tx); mty = int'(ty); mgp = int'(grav_period);
            mmode = mode; mw = int'(obj_w); mh = int'(obj_h);
         end
      end else if (kill) begin
         mmov = 0;
      end else begin
         mt++;
         xt = (mtx != 0) && (mt % mtx == 0);
         yt = (mty != 0) && (mt % mty == 0);
         gt = mmode && (mgp != 0) && (mt % mgp == 0);
         ny = my + mvy;
         if (yt && mmode && ny >= SH) begin
            ex = 1; mmov = 0;
         end else begin
            if (xt) begin
               c = mx + mdir;
               if (c < 0 || c > SW - mw) begin
                  mdir = -mdir; bx = 1;
               end else mx = c;
            end
            nv = mvy;
            if (yt) begin
               if (ny < 0) begin
                  my = 0; nv = -mvy; by = 1;
               end else if (!mmode && ny > SH - mh) begin
                  my = SH - mh; nv = -mvy; by = 1;
               end else my = ny;
            end
            if (gt) nv = nv + 1;
            if (nv > 127) nv = 127;
            mvy = nv;
         end
      end
      e.x = mx;
      e.y = my;
      e.flags = {27'd0, mmov, ack, bx, by, ex};
      q.push_back(e);
   endtask

   // Inputs are set between edges; model predicts the post-edge outputs
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_obj(input int x0, input int y0, input int w,
                          input int h, input int px, input int py,
                          input int gp, input bit d, input int v,
                          input bit md);
      init_x = 10'(x0); init_y = 9'(y0);
      obj_w = 10'(w); obj_h = 9'(h);
      tx = 32'(px); ty = 32'(py); grav_period = 32'(gp);
      dir_x = d; vy0 = 8'(v); mode = md;
   endtask

   task automatic do_launch();
      launch = 1'b1;
      step();
      launch = 1'b0;
   endtask

   task automatic do_kill();
      kill = 1'b1;
      step();
      kill = 1'b0;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pos_x", int'(pos_x), e.x);
            chk("pos_y", int'(pos_y), e.y);
            chk("flags{act,ack,bx,by,ex}",
                int'({active, launch_ack, bounce_x, bounce_y, exited}),
                e.flags);
         end
      end
   end

   initial begin
      int w, h;
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; launch = 1'b0; kill = 1'b0;
      set_obj(0, 0, 8, 8, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      steps(2);
      rst = 1'b0;
      steps(2);

      // Right-wall bounce
      set_obj(630, 100, 8, 10, 1, 0, 0, 0, 0, 0);
      do_launch();
      steps(6);
      do_kill();

      // Projectile arc to the floor
      set_obj(50, 400, 8, 10, 0, 1, 2, 0, -4, 1);
      do_launch();
      for (int i = 0; i < 200 && mmov; i++) step();
      steps(2);

      // Top clamp in bounce mode
      set_obj(50, 3, 8, 10, 0, 1, 0, 0, -5, 0);
      do_launch();
      steps(4);
      do_kill();

      // Kill on the exiting tick
      set_obj(50, 460, 8, 10, 0, 1, 0, 0, 2, 1);
      do_launch();
      for (int i = 0; i < 50 && mmov; i++) begin
         if (my + mvy >= SH) begin
            do_kill();
            break;
         end
         step();
      end
      set_obj(100, 50, 8, 10, 0, 0, 0, 0, 0, 1);
      do_launch();
      steps(2);
      do_kill();

      // Launch in MOVE ignored, periods stay latched
      set_obj(300, 50, 8, 10, 4, 0, 0, 0, 0, 0);
      do_launch();
      steps(3);
      set_obj(10, 20, 8, 10, 1, 1, 1, 1, 3, 1);
      do_launch();
      steps(10);
      do_kill();

      // Reset mid-flight with launch held
      set_obj(200, 200, 8, 10, 1, 1, 0, 0, 2, 0);
      do_launch();
      steps(3);
      rst = 1'b1; launch = 1'b1;
      steps(2);
      rst = 1'b0;
      step();
      launch = 1'b0;
      steps(3);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         w = $urandom_range(1, 40);
         h = $urandom_range(1, 40);
         set_obj(($urandom_range(0, 1) == 1) ? SW - w - $urandom_range(0, 3)
                                             : $urandom_range(0, SW - w),
                 $urandom_range(0, SH - h), w, h,
                 $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 40) - 20, 1'($urandom_range(0, 1)));
         rst    = ($urandom_range(0, 199) == 0);
         launch = ($urandom_range(0, 2) == 0);
         kill   = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0; launch = 1'b0; kill = 1'b0;
      @(posedge clk);
      #2;
      chk("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
